// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: column strobe, row sampling, scan-level debounce,
// hex decode and a 4-digit shift-in entry register. Optional KEYPAD_CLEAR_EN: key F clears nums.
module keypad_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        basys3_clk,
    input  logic        clr_n,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] nums
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Row r, column c -> hex code (Pmod KYPD layout).
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    logic [3:0]       row_s1_q, row_s1_d;
    logic [3:0]       row_s2_q, row_s2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       c_q, c_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       hit_cnt_q, hit_cnt_d;
    logic [3:0]       hit_key_q, hit_key_d;
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic [15:0]      nums_q, nums_d;

    // Per-column sample folded into the running scan result.
    // hit_cnt saturates at 2, which already means MULTI.
    logic [3:0] row_low;
    logic [2:0] low_cnt;
    logic [1:0] low_row;
    logic [2:0] scan_sum;
    logic [1:0] merged_cnt;
    logic [3:0] merged_key;

    always_comb begin
        row_low = ~row_s2_q;
        low_cnt = 3'd0;
        low_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) begin
                low_cnt = low_cnt + 3'd1;
                low_row = 2'(r);
            end
        end
        scan_sum   = {1'b0, hit_cnt_q} + low_cnt;
        merged_cnt = (scan_sum >= 3'd2) ? 2'd2 : scan_sum[1:0];
        merged_key = (hit_cnt_q == 2'd0) ? key_map(low_row, c_q) : hit_key_q;
    end

    logic       sample;
    logic       scan_end;
    logic       scan_none;
    logic       scan_single;
    logic [3:0] cnt_inc;
    logic       do_accept;

    always_comb begin
        row_s1_d    = row;
        row_s2_d    = row_s1_q;
        div_d       = div_q;
        c_d         = c_q;
        col_d       = col_q;
        hit_cnt_d   = hit_cnt_q;
        hit_key_d   = hit_key_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        nums_d      = nums_q;
        do_accept   = 1'b0;

        sample      = (div_q == DIV_LAST);
        scan_end    = sample && (c_q == 2'd3);
        scan_none   = (merged_cnt == 2'd0);
        scan_single = (merged_cnt == 2'd1);
        cnt_inc     = cnt_q + 4'd1;

        div_d = sample ? '0 : div_q + DIV_W'(1);

        if (sample) begin
            c_d   = c_q + 2'd1;
            col_d = ~(4'b0001 << c_d);
            if (scan_end) begin
                hit_cnt_d = 2'd0;
                hit_key_d = 4'h0;
            end else begin
                hit_cnt_d = merged_cnt;
                hit_key_d = merged_key;
            end
        end

        // Debounce decision is taken once per scan, on the column-3 sample.
        if (scan_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_single && merged_key == cand_q) begin
                        if (cnt_inc == DEB_N) begin
                            do_accept = 1'b1;
                            state_d   = ST_HELD;
                            cnt_d     = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (scan_single) begin
                        cand_d = merged_key;
                        if (DEB_N == 4'd1) begin
                            do_accept = 1'b1;
                            state_d   = ST_HELD;
                            cnt_d     = 4'd0;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (scan_none) begin
                        if (cnt_inc == DEB_N) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        if (do_accept) begin
            key_code_d  = merged_key;
            key_valid_d = 1'b1;
`ifdef KEYPAD_CLEAR_EN
            if (merged_key == 4'hF) begin
                nums_d = 16'h0000;
            end else begin
                nums_d = {nums_q[11:0], merged_key};
            end
`else
            nums_d = {nums_q[11:0], merged_key};
`endif
        end
    end

    always_ff @(posedge basys3_clk) begin
        if (!clr_n) begin
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
            div_q       <= '0;
            c_q         <= 2'd0;
            col_q       <= 4'b1110;
            hit_cnt_q   <= 2'd0;
            hit_key_q   <= 4'h0;
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            nums_q      <= 16'h0000;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            div_q       <= div_d;
            c_q         <= c_d;
            col_q       <= col_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_key_q   <= hit_key_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            nums_q      <= nums_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign nums      = nums_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=2) with a strobe-driven keypad model.
// Honours KEYPAD_CLEAR_EN when the same macro is defined for the bench.
module tb_keypad_scan;
  logic        clk = 1'b0;
  logic        clr_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] nums;

  // keys[r*4+c] = 1 means the key at row r, column c is held down.
  logic [15:0] keys = 16'h0000;

  int n_cmp = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .basys3_clk(clk),
    .clr_n(clr_n),
    .col(col),
    .row(row),
    .key_code(key_code),
    .key_valid(key_valid),
    .nums(nums)
  );

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) if (key_valid === 1'b1) pulse_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Leaves the caller on the first negedge of a scan (col just returned to 1110).
  task automatic align_scan();
    int n = 0;
    while (col !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (col !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL align_scan: col=%b did not wrap within 100 cycles", col);
    end
  endtask

  task automatic press_key(input int r, input int c, input int hold, input int rel);
    align_scan();
    keys = 16'(1) << (r*4 + c);
    repeat (hold*16) @(negedge clk);
    keys = 16'h0000;
    repeat (rel*16) @(negedge clk);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b expected %b", col, 4'b1110); end
    n_cmp++; if (nums !== 16'h0000) begin n_fail++; $display("FAIL reset_nums: got %h expected %h", nums, 16'h0000); end
    n_cmp++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h expected %h", key_code, 4'h0); end
    n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    int base;
    base = pulse_cnt;
    clr_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      n_cmp++; if (col !== exp_col) begin n_fail++; $display("FAIL idle_col[%0d]: got %b expected %b", k, col, exp_col); end
      @(negedge clk);
    end
    repeat (84) @(negedge clk);
    n_cmp++; if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL idle_pulses: got %0d expected 0", pulse_cnt - base); end
    n_cmp++; if (nums !== 16'h0000) begin n_fail++; $display("FAIL idle_nums: got %h expected %h", nums, 16'h0000); end
  endtask

  task automatic test_single_press();
    int base;
    base = pulse_cnt;
    align_scan();
    keys = 16'(1) << 5;
    repeat (31) @(negedge clk);
    n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", key_valid); end
    @(negedge clk);
    n_cmp++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_timing: got %b expected 1", key_valid); end
    n_cmp++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL single_key_code: got %h expected %h", key_code, 4'h5); end
    repeat (8*16) @(negedge clk);
    keys = 16'h0000;
    repeat (3*16) @(negedge clk);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulse_cnt - base); end
    n_cmp++; if (nums !== 16'h0005) begin n_fail++; $display("FAIL single_nums: got %h expected %h", nums, 16'h0005); end
  endtask

  task automatic test_sequence();
    int seq_r[5]    = '{0, 0, 0, 0, 1};
    int seq_c[5]    = '{0, 1, 2, 3, 0};
    logic [3:0] seq_code[5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4};
    logic [15:0] exp_nums;
    int base;
    exp_q.push_back(16'h0051);
    exp_q.push_back(16'h0512);
    exp_q.push_back(16'h5123);
    exp_q.push_back(16'h123A);
    exp_q.push_back(16'h23A4);
    for (int i = 0; i < 5; i++) begin
      base = pulse_cnt;
      press_key(seq_r[i], seq_c[i], 3, 3);
      exp_nums = exp_q.pop_front();
      n_cmp++; if (nums !== exp_nums) begin n_fail++; $display("FAIL seq_nums[%0d]: got %h expected %h", i, nums, exp_nums); end
      n_cmp++; if (key_code !== seq_code[i]) begin n_fail++; $display("FAIL seq_key_code[%0d]: got %h expected %h", i, key_code, seq_code[i]); end
      n_cmp++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL seq_pulses[%0d]: got %0d expected 1", i, pulse_cnt - base); end
    end
  endtask

  task automatic test_bounce();
    int base;
    base = pulse_cnt;
    align_scan();
    for (int s = 0; s < 8; s++) begin
      keys = (s % 2 == 0) ? (16'(1) << 8) : 16'h0000;
      repeat (16) @(negedge clk);
    end
    n_cmp++; if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 0", pulse_cnt - base); end
    keys = 16'(1) << 8;
    repeat (31) @(negedge clk);
    n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_early_valid: got %b expected 0", key_valid); end
    @(negedge clk);
    n_cmp++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL bounce_valid_timing: got %b expected 1", key_valid); end
    repeat (32) @(negedge clk);
    keys = 16'h0000;
    repeat (3*16) @(negedge clk);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL bounce_hold_pulses: got %0d expected 1", pulse_cnt - base); end
    n_cmp++; if (nums !== 16'h3A47) begin n_fail++; $display("FAIL bounce_nums: got %h expected %h", nums, 16'h3A47); end
  endtask

  task automatic test_multi();
    int base;
    base = pulse_cnt;
    align_scan();
    keys = 16'h0003;
    repeat (6*16) @(negedge clk);
    keys = 16'h0000;
    repeat (3*16) @(negedge clk);
    n_cmp++; if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL multi_pulses: got %0d expected 0", pulse_cnt - base); end
    n_cmp++; if (nums !== 16'h3A47) begin n_fail++; $display("FAIL multi_nums: got %h expected %h", nums, 16'h3A47); end
    base = pulse_cnt;
    press_key(0, 1, 3, 3);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL multi_after_pulses: got %0d expected 1", pulse_cnt - base); end
    n_cmp++; if (key_code !== 4'h2) begin n_fail++; $display("FAIL multi_after_key_code: got %h expected %h", key_code, 4'h2); end
    n_cmp++; if (nums !== 16'hA472) begin n_fail++; $display("FAIL multi_after_nums: got %h expected %h", nums, 16'hA472); end
  endtask

  task automatic test_mid_reset();
    int base;
    align_scan();
    keys = 16'(1) << 8;
    repeat (20) @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    base = pulse_cnt;
    n_cmp++; if (col !== 4'b1110) begin n_fail++; $display("FAIL midrst_col: got %b expected %b", col, 4'b1110); end
    n_cmp++; if (nums !== 16'h0000) begin n_fail++; $display("FAIL midrst_nums: got %h expected %h", nums, 16'h0000); end
    n_cmp++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL midrst_key_code: got %h expected %h", key_code, 4'h0); end
    n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_key_valid: got %b expected 0", key_valid); end
    repeat (16) @(negedge clk);
    n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_partial_debounce: got %b expected 0", key_valid); end
    repeat (16) @(negedge clk);
    n_cmp++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_valid_timing: got %b expected 1", key_valid); end
    repeat (32) @(negedge clk);
    keys = 16'h0000;
    repeat (3*16) @(negedge clk);
    n_cmp++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL midrst_pulses: got %0d expected 1", pulse_cnt - base); end
    n_cmp++; if (nums !== 16'h0007) begin n_fail++; $display("FAIL midrst_nums_after: got %h expected %h", nums, 16'h0007); end
  endtask

  task automatic test_clear();
    logic [15:0] exp_f;
    press_key(0, 0, 3, 3);
    press_key(0, 1, 3, 3);
    press_key(0, 2, 3, 3);
    press_key(1, 0, 3, 3);
    n_cmp++; if (nums !== 16'h1234) begin n_fail++; $display("FAIL clear_setup_nums: got %h expected %h", nums, 16'h1234); end
    press_key(3, 1, 3, 3);
`ifdef KEYPAD_CLEAR_EN
    exp_f = 16'h0000;
`else
    exp_f = 16'h234F;
`endif
    n_cmp++; if (nums !== exp_f) begin n_fail++; $display("FAIL clear_f_nums: got %h expected %h", nums, exp_f); end
    n_cmp++; if (key_code !== 4'hF) begin n_fail++; $display("FAIL clear_f_key_code: got %h expected %h", key_code, 4'hF); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_press();
    test_sequence();
    test_bounce();
    test_multi();
    test_mid_reset();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
